// File: rtl/led_seq_ctrl_if.sv
// led_seq_ctrl_if: memory-mapped bus; the master side arbitrates with req/gnt
interface led_seq_ctrl_if #(parameter int MM_ADDR_WIDTH = 8, parameter int MM_DATA_WIDTH = 16);
  logic req, gnt, we;
  logic [MM_ADDR_WIDTH-1:0] addr;
  logic [MM_DATA_WIDTH-1:0] wdata, rdata;
  modport master (output req, addr, wdata, we, input gnt);
  modport slave (input addr, wdata, we, output rdata);
endinterface

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: steps a 4-entry LED pattern table into the LED controller register over an arbitrated MM master port
// Optional SEQ_IRQ_EN adds seq_irq_o and a sticky IRQ flag in STAT bit4.
module led_seq_ctrl #(
  parameter int MM_ADDR_WIDTH = 8,
  parameter int MM_DATA_WIDTH = 16,
  parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_SEQ_CTRL = 'h10,
  parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_SEQ_PAT0 = 'h11,
  parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_SEQ_STAT = 'h15,
  parameter logic [MM_ADDR_WIDTH-1:0] LED_CTRL_ADDR = 'h0E
) (
  input  logic clk_sys_i,
  input  logic rst_n_i,
  input  logic clk_8hz_i,
  led_seq_ctrl_if.slave mm_s,
  led_seq_ctrl_if.master mm_m,
  output logic seq_busy_o
`ifdef SEQ_IRQ_EN
  ,
  output logic seq_irq_o
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, WRITE, WAIT} state_t;
  state_t state;
  logic en, oneshot, done, tick, step;
  logic [1:0] last, idx;
  logic [7:0] period, cnt;
  logic [2:0] sync;
  logic [8:0] cnt_nx;
  logic [11:0] stat;
  logic [MM_DATA_WIDTH-1:0] pat [4];
  assign cnt_nx = {1'b0, cnt} + 9'd1;
  assign step = tick && (cnt_nx >= {1'b0, (period == 8'd0) ? 8'd1 : period});
`ifdef SEQ_IRQ_EN
  logic irq_flag, fire;
  assign fire = state == WAIT && en && step && !(idx < last);
  // the IRQ flag takes the LSB of the tick count field
  assign stat = {cnt[7:1], irq_flag, done, seq_busy_o, idx};
`else
  assign stat = {cnt, done, seq_busy_o, idx};
`endif
  always_comb begin
    mm_s.rdata = '0;
    if (mm_s.addr == REG_ADDR_SEQ_CTRL) mm_s.rdata = MM_DATA_WIDTH'({period, last, oneshot, en});
    if (mm_s.addr == REG_ADDR_SEQ_STAT) mm_s.rdata = MM_DATA_WIDTH'(stat);
    for (int k = 0; k < 4; k++)
      if (mm_s.addr == REG_ADDR_SEQ_PAT0 + MM_ADDR_WIDTH'(k)) mm_s.rdata = pat[k];
  end
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      {en, oneshot, done, tick} <= '0;
      {last, idx, period, cnt, sync} <= '0;
      pat <= '{default: '0};
      mm_m.req <= 1'b0;
      mm_m.we <= 1'b0;
      mm_m.addr <= '0;
      mm_m.wdata <= '0;
      seq_busy_o <= 1'b0;
`ifdef SEQ_IRQ_EN
      seq_irq_o <= 1'b0;
      irq_flag <= 1'b0;
`endif
    end else begin
      sync <= {sync[1:0], clk_8hz_i};
      tick <= sync[1] & ~sync[2];
      if (mm_s.we && mm_s.addr == REG_ADDR_SEQ_CTRL) {period, last, oneshot, en} <= mm_s.wdata[11:0];
      for (int k = 0; k < 4; k++)
        if (mm_s.we && mm_s.addr == REG_ADDR_SEQ_PAT0 + MM_ADDR_WIDTH'(k)) pat[k] <= mm_s.wdata;
`ifdef SEQ_IRQ_EN
      seq_irq_o <= 1'b0;
      if (mm_s.we && mm_s.addr == REG_ADDR_SEQ_STAT) irq_flag <= 1'b0;
      if (fire) begin
        seq_irq_o <= 1'b1;
        irq_flag <= 1'b1;
      end
`endif
      case (state)
        IDLE: if (en) begin
          idx <= '0;
          done <= 1'b0;
          state <= REQ;
          mm_m.req <= 1'b1;
          seq_busy_o <= 1'b1;
        end
        REQ: if (!en) begin
          state <= IDLE;
          mm_m.req <= 1'b0;
          seq_busy_o <= 1'b0;
        end else if (mm_m.gnt) begin
          state <= WRITE;
          mm_m.we <= 1'b1;
          mm_m.addr <= LED_CTRL_ADDR;
          mm_m.wdata <= pat[idx];
        end
        WRITE: begin
          mm_m.we <= 1'b0;
          mm_m.addr <= '0;
          mm_m.wdata <= '0;
          mm_m.req <= 1'b0;
          cnt <= '0;
          state <= en ? WAIT : IDLE;
          seq_busy_o <= en;
        end
        WAIT: if (!en) begin
          state <= IDLE;
          seq_busy_o <= 1'b0;
        end else if (step) begin
          // idx beyond a shrunk LAST falls into the wrap/done branch
          if (idx < last) begin
            idx <= idx + 2'd1;
            state <= REQ;
            mm_m.req <= 1'b1;
          end else if (!oneshot) begin
            idx <= '0;
            state <= REQ;
            mm_m.req <= 1'b1;
          end else begin
            done <= 1'b1;
            en <= 1'b0;
            state <= IDLE;
            seq_busy_o <= 1'b0;
          end
        end else if (tick) cnt <= cnt + 8'd1;
      endcase
    end
  end
endmodule
